// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and widths for the memory responder.
//   state_t : responder FSM state (IDLE / WAIT / RESP)
//   CNT_W   : wait-cycle counter width (LATENCY range 0..15)
//   WORD_W  : data word width
//   ADDR_W  : byte address width
package mem_resp_pkg;

    localparam int CNT_W  = 4;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: single-port synchronous word array.
//   clk   : clock
//   rst   : synchronous active-high reset (clears the read register only)
//   we    : write enable, writes wdata to addr on the rising edge
//   re    : read enable, loads rdata from addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, held while re is low
module mem_resp_ram
    import mem_resp_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU bus.
// Accepts one word access in IDLE, waits LATENCY cycles, then completes the
// read or write against an internal array with a one-cycle ready pulse.
//   clk, rst  : clock, synchronous active-high reset
//   req       : access request, sampled only in IDLE
//   we        : 1 = write, 0 = read (sampled with req)
//   adr       : byte address (sampled with req)
//   wdata     : write data (sampled with req)
//   rdata     : read data, valid with ready on a read, held until next read
//   ready     : one-cycle completion pulse
//   err       : access fault, qualified by ready
//   dbg_state : current FSM state for observation
// Optional feature macro: MEM_RESP_ERR_EN (misaligned / out-of-range faults).
//
// Handshake: the initiator raises req with we/adr/wdata; the responder takes
// them on the first rising edge where it is IDLE and req=1 (acceptance), then
// ignores all inputs until ready has pulsed for exactly one cycle. ready is
// never high in two consecutive cycles.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output state_t            dbg_state
);

    localparam int               IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT   = CNT_W'(LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_adr;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_fault;
    logic              enter_resp;
    logic              ram_we;
    logic              ram_re;
    logic [WORD_W-1:0] ram_rdata;

    // With LATENCY=0 the array is read on the acceptance edge itself, before
    // the holding registers are loaded, so the live inputs are used in IDLE.
    assign acc_we  = (state == IDLE) ? we  : we_q;
    assign acc_adr = (state == IDLE) ? adr : adr_q;
    assign acc_idx = IDX_W'((acc_adr - BASE_ADDR) >> 2);

    assign enter_resp = ((state == IDLE) && req && (LAT == '0)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));

    // Write lands on the edge that ends RESP; a reset on that edge cancels it.
    assign ram_we = (state == RESP) && we_q && !acc_fault && !rst;
    assign ram_re = enter_resp && !acc_we && !acc_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            ready   <= 1'b0;
        end else begin
            ready <= enter_resp;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        adr_q   <= adr;
                        wdata_q <= wdata;
                        cnt     <= LAT;
                        state   <= (LAT == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic [ADDR_W-1:0] acc_off;
    logic              rd_zero;

    // Unsigned offset from the base: addresses below BASE_ADDR wrap to large
    // values and fall out of range along with those above the top.
    assign acc_off   = acc_adr - BASE_ADDR;
    assign acc_fault = (acc_off[1:0] != 2'b00) ||
                       ((acc_off >> (IDX_W + 2)) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            rd_zero <= 1'b0;
        end else begin
            err <= enter_resp && acc_fault;
            if (enter_resp && !acc_we) begin
                rd_zero <= acc_fault;
            end
        end
    end

    // A faulted read presents zero; the array read register is left untouched.
    assign rdata = rd_zero ? '0 : ram_rdata;
`else
    assign acc_fault = 1'b0;
    assign err       = 1'b0;
    assign rdata     = ram_rdata;
`endif

    assign dbg_state = state;

    mem_resp_ram #(
        .DEPTH (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Two instances share clk/rst: dut_a with LATENCY=2, dut_b with LATENCY=0,
// both with a 16-word array at base 0. Expectations follow MEM_RESP_ERR_EN.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [31:0] adr_a = '0, wdata_a = '0, rdata_a;
    logic        ready_a, err_a;
    state_t      dbg_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] adr_b = '0, wdata_b = '0, rdata_b;
    logic        ready_b, err_b;
    state_t      dbg_b;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .adr(adr_a), .wdata(wdata_a),
        .rdata(rdata_a), .ready(ready_a), .err(err_a), .dbg_state(dbg_a)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .adr(adr_b), .wdata(wdata_b),
        .rdata(rdata_b), .ready(ready_b), .err(err_b), .dbg_state(dbg_b)
    );

`ifdef MEM_RESP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Back-to-back ready detector on both instances.
    int   consec = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        consec <= consec + int'(ready_a && prev_a) + int'(ready_b && prev_b);
        prev_a <= ready_a;
        prev_b <= ready_b;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit b, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (b) begin
            req_b = r; we_b = w; adr_b = a; wdata_b = d;
        end else begin
            req_a = r; we_a = w; adr_a = a; wdata_a = d;
        end
    endtask

    // One complete access from IDLE: checks ready in every cycle of the window,
    // err with ready, and for reads rdata with ready and one cycle later.
    task automatic access(input bit b, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        int          lat;
        logic [31:0] hold;
        logic        rdy, er;
        logic [31:0] rd;
        lat  = b ? LAT_B : LAT_A;
        hold = '0;
        @(negedge clk);
        drive(b, 1'b1, w, a, d);
        if (!w) exp_q.push_back(exp_rd);
        @(posedge clk);
        for (int j = 1; j <= lat + 2; j++) begin
            @(negedge clk);
            if (j == 1) drive(b, 1'b0, w, a, d);
            rdy = b ? ready_b : ready_a;
            er  = b ? err_b : err_a;
            rd  = b ? rdata_b : rdata_a;
            check($sformatf("%s ready c%0d", tag, j), 32'(rdy), 32'(j == lat + 1));
            if (j == lat + 1) begin
                check({tag, " err"}, 32'(er), 32'(exp_err));
                if (!w) begin
                    hold = exp_q.pop_front();
                    check({tag, " rdata"}, rd, hold);
                end
            end
            if (j == lat + 2 && !w) check({tag, " rdata hold"}, rd, hold);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst ready_a", 32'(ready_a), 32'd0);
        check("rst err_a",   32'(err_a),   32'd0);
        check("rst rdata_a", rdata_a,      32'd0);
        check("rst state_a", 32'(dbg_a),   32'(IDLE));
        check("rst ready_b", 32'(ready_b), 32'd0);
        check("rst rdata_b", rdata_b,      32'd0);

        // Write then read at LATENCY=2.
        access(0, 1, 32'h10, 32'hDEAD_BEEF, '0, 0, "wr10");
        access(0, 0, 32'h10, '0, 32'hDEAD_BEEF, 0, "rd10");

        // Index DEPTH wraps onto word 0 unless faulted.
        access(0, 1, 32'h00, 32'h1111_1111, '0, 0, "wr00");
        access(0, 1, 32'h40, 32'h2222_2222, '0, ERR_EN, "wr40");
        access(0, 0, 32'h00, '0, ERR_EN ? 32'h1111_1111 : 32'h2222_2222, 0, "rd00");

        // Misaligned read: fault with zero data, or low bits ignored (word 4).
        access(0, 0, 32'h13, '0, ERR_EN ? 32'h0 : 32'hDEAD_BEEF, ERR_EN, "rd13");

        // Inputs changed and req toggled while the write to 0x24 waits.
        access(0, 1, 32'h28, 32'h0, '0, 0, "wr28");
        @(negedge clk);
        drive(0, 1, 1, 32'h24, 32'hA5A5_A5A5);
        @(posedge clk);
        @(negedge clk);
        check("tog ready c1", 32'(ready_a), 32'd0);
        drive(0, 0, 1, 32'h28, 32'h5A5A_5A5A);
        @(negedge clk);
        check("tog ready c2", 32'(ready_a), 32'd0);
        drive(0, 1, 1, 32'h28, 32'h5A5A_5A5A);
        @(negedge clk);
        check("tog ready c3", 32'(ready_a), 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int j = 4; j <= 8; j++) begin
            @(negedge clk);
            check($sformatf("tog ready c%0d", j), 32'(ready_a), 32'd0);
        end
        access(0, 0, 32'h24, '0, 32'hA5A5_A5A5, 0, "rd24");
        access(0, 0, 32'h28, '0, 32'h0, 0, "rd28");

        // LATENCY=0: back-to-back reads with req held high.
        access(1, 1, 32'h0, 32'h0BAD_F00D, '0, 0, "b wr0");
        access(1, 1, 32'h4, 32'h600D_CAFE, '0, 0, "b wr4");
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("b2b ready c1", 32'(ready_b), 32'd1);
        check("b2b rdata c1", rdata_b, 32'h0BAD_F00D);
        drive(1, 1, 0, 32'h4, 32'h0);
        @(negedge clk);
        check("b2b ready c2", 32'(ready_b), 32'd0);
        check("b2b state c2", 32'(dbg_b), 32'(IDLE));
        @(negedge clk);
        check("b2b ready c3", 32'(ready_b), 32'd1);
        check("b2b rdata c3", rdata_b, 32'h600D_CAFE);
        drive(1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b ready c4", 32'(ready_b), 32'd0);
        check("b2b rdata hold", rdata_b, 32'h600D_CAFE);

        // Reset during WAIT of a write to 0x20 abandons it.
        access(0, 1, 32'h20, 32'h1234_5678, '0, 0, "wr20");
        @(negedge clk);
        drive(0, 1, 1, 32'h20, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        check("abort state c1", 32'(dbg_a), 32'(WAIT));
        drive(0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", 32'(dbg_a), 32'(IDLE));
        check("abort rdata", rdata_a, 32'd0);
        for (int j = 2; j <= 6; j++) begin
            @(negedge clk);
            check($sformatf("abort ready c%0d", j), 32'(ready_a), 32'd0);
        end
        access(0, 0, 32'h20, '0, 32'h1234_5678, 0, "rd20");

        check("no consecutive ready", 32'(consec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
